// File: rtl/sap_ctrl_seq.sv
// sap_ctrl_seq: controller-sequencer for the SAP datapath.
// Runs a one-hot T1..T6 ring and decodes the IR opcode into the control word
// (load/enable/count strobes) for PC, MAR, RAM, IR, A, B, ALU and OUT.
//
// Optional feature macro: SAP_CTRL_JMP_EN (adds o_lp and the JMP opcode 0011).
//
// Ports:
//   clk       system clock, state changes on posedge
//   clr       asynchronous active-high reset
//   i_run     1 = ring advances each posedge, 0 = pause (control word forced 0)
//   i_opcode  upper nibble of IR, valid from T4
//   o_tstate  one-hot current T-state, bit0 = T1
//   o_cp/o_ep PC increment / PC drives bus
//   o_lm      MAR load
//   o_ce      RAM drives bus
//   o_li/o_ei IR load / IR operand drives bus
//   o_la/o_ea A load / A drives bus
//   o_su/o_eu ALU subtract select / ALU drives bus
//   o_lb      B load
//   o_lo      output register load
//   o_hlt     halted flag
//   o_lp      PC load (only with SAP_CTRL_JMP_EN)
module sap_ctrl_seq #(
  parameter int unsigned OPW = 4,
  parameter int unsigned NT  = 6
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           i_run,
  input  logic [OPW-1:0] i_opcode,
  output logic [NT-1:0]  o_tstate,
  output logic           o_cp,
  output logic           o_ep,
  output logic           o_lm,
  output logic           o_ce,
  output logic           o_li,
  output logic           o_ei,
  output logic           o_la,
  output logic           o_ea,
  output logic           o_su,
  output logic           o_eu,
  output logic           o_lb,
  output logic           o_lo,
  output logic           o_hlt
`ifdef SAP_CTRL_JMP_EN
  ,
  output logic           o_lp
`endif
);

  localparam logic [NT-1:0] T1 = NT'(6'b000001);
  localparam logic [NT-1:0] T2 = NT'(6'b000010);
  localparam logic [NT-1:0] T3 = NT'(6'b000100);
  localparam logic [NT-1:0] T4 = NT'(6'b001000);
  localparam logic [NT-1:0] T5 = NT'(6'b010000);
  localparam logic [NT-1:0] T6 = NT'(6'b100000);

  localparam logic [OPW-1:0] OP_LDA = OPW'(4'b0000);
  localparam logic [OPW-1:0] OP_ADD = OPW'(4'b0001);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4'b0010);
  localparam logic [OPW-1:0] OP_OUT = OPW'(4'b1110);
  localparam logic [OPW-1:0] OP_HLT = OPW'(4'b1111);
`ifdef SAP_CTRL_JMP_EN
  localparam logic [OPW-1:0] OP_JMP = OPW'(4'b0011);
`endif

  logic [NT-1:0] tstate;
  logic [NT-1:0] tstate_nxt;
  logic          halted;
  logic          halted_nxt;
  logic          active;

  // State register: ring position and halted flag.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      tstate <= T1;
      halted <= 1'b0;
    end else begin
      tstate <= tstate_nxt;
      halted <= halted_nxt;
    end
  end

  // Next state: rotate while running; HLT in T4 freezes the ring at T4.
  always_comb begin
    tstate_nxt = tstate;
    halted_nxt = halted;
    if (i_run && !halted) begin
      if (tstate == T4 && i_opcode == OP_HLT) begin
        halted_nxt = 1'b1;
      end else begin
        tstate_nxt = {tstate[NT-2:0], tstate[NT-1]};
      end
    end
  end

  // Control word is only asserted while running and not halted.
  assign active = i_run & ~halted;

  // Output decode from (T-state, opcode).
  always_comb begin
    o_cp = 1'b0;
    o_ep = 1'b0;
    o_lm = 1'b0;
    o_ce = 1'b0;
    o_li = 1'b0;
    o_ei = 1'b0;
    o_la = 1'b0;
    o_ea = 1'b0;
    o_su = 1'b0;
    o_eu = 1'b0;
    o_lb = 1'b0;
    o_lo = 1'b0;
`ifdef SAP_CTRL_JMP_EN
    o_lp = 1'b0;
`endif
    if (active) begin
      case (tstate)
        T1: begin
          o_ep = 1'b1;
          o_lm = 1'b1;
        end
        T2: o_cp = 1'b1;
        T3: begin
          o_ce = 1'b1;
          o_li = 1'b1;
        end
        T4: begin
          case (i_opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              o_ei = 1'b1;
              o_lm = 1'b1;
            end
            OP_OUT: begin
              o_ea = 1'b1;
              o_lo = 1'b1;
            end
`ifdef SAP_CTRL_JMP_EN
            OP_JMP: begin
              o_ei = 1'b1;
              o_lp = 1'b1;
            end
`endif
            default: ;
          endcase
        end
        T5: begin
          case (i_opcode)
            OP_LDA: begin
              o_ce = 1'b1;
              o_la = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              o_ce = 1'b1;
              o_lb = 1'b1;
            end
            default: ;
          endcase
        end
        T6: begin
          case (i_opcode)
            OP_ADD: begin
              o_eu = 1'b1;
              o_la = 1'b1;
            end
            OP_SUB: begin
              o_eu = 1'b1;
              o_la = 1'b1;
              o_su = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign o_tstate = tstate;
  assign o_hlt    = halted;

endmodule

// File: doc/sap_ctrl_seq.md
Name: sap_ctrl_seq

Overview:
- Controller-sequencer for the SAP datapath.
- Runs a 6-state ring counter (T1..T6) and decodes the instruction-register opcode into the active-high load/enable/count control word for the PC, MAR, RAM, IR, A, B, ALU and output registers. Each of those registers is a dff_posedge-style register with an i_en load.
- Sits between the instruction register and every datapath register; sole source of all i_en strobes and bus-drive enables.

Parameters:
- OPW, 4, opcode width; opcode values below are defined at OPW=4.
- NT, 6, number of T-states in the ring. Fixed at 6; other values are unsupported.

Ports:
- clk  input  1  system clock, all state changes on posedge
- clr  input  1  asynchronous, active-high reset
- i_run  input  1  1 = ring advances each posedge; 0 = pause
- i_opcode  input  OPW  upper nibble of IR, valid from T4
- o_tstate  output  NT  one-hot current T-state, bit0 = T1
- o_cp  output  1  PC increment
- o_ep  output  1  PC drives bus
- o_lm  output  1  MAR load
- o_ce  output  1  RAM drives bus
- o_li  output  1  IR load
- o_ei  output  1  IR operand drives bus
- o_la  output  1  A load
- o_ea  output  1  A drives bus
- o_su  output  1  ALU subtract select
- o_eu  output  1  ALU drives bus
- o_lb  output  1  B load
- o_lo  output  1  output register load
- o_hlt  output  1  halted flag

Behaviour:
- Reset:
  - Asynchronous, active-high on clr: clk and reset polarity/synchronicity are fixed as stated.
  - clr=1 forces o_tstate=6'b000001 and o_hlt=0 immediately, independent of clk.
  - Control outputs then show the T1 word, gated by i_run.
  - clr mid-instruction aborts it; no partial-state retention.
- Ring counter: on posedge with i_run=1 and halted=0: T1->T2->...->T6->T1 (rotate left). Otherwise hold.
- Control word: combinational from (o_tstate, i_opcode). Every output not listed for a state is 0.
  - Fetch, all opcodes:
    - T1: ep, lm
    - T2: cp
    - T3: ce, li
  - LDA (0000): T4 ei,lm; T5 ce,la; T6 none
  - ADD (0001): T4 ei,lm; T5 ce,lb; T6 eu,la
  - SUB (0010): T4 ei,lm; T5 ce,lb; T6 eu,la,su
  - OUT (1110): T4 ea,lo; T5,T6 none
  - HLT (1111): T4 none; posedge in T4 with i_run=1 sets halted=1, and the ring holds at T4.
  - Any other opcode: NOP, T4..T6 none.
- Halted:
  - All control outputs are 0 and o_hlt=1.
  - The ring stays at T4; only clr clears the halted state.
- Pause (i_run=0):
  - All control outputs are forced to 0, so there are no repeated loads or counts.
  - Ring and halted flag hold.
  - Resuming with i_run=1 restores the current state's word in the same cycle.
- Invariants:
  - At most one bus driver (ep, ce, ei, ea, eu) is high in any cycle.
  - o_tstate is always exactly one-hot.
  - Latency: one instruction takes 6 clocks (HLT: 4 clocks to halt).
- opcode change mid-T4..T6: the control word follows i_opcode combinationally. Holding it stable is the IR's responsibility (IR loads only at T3).

Optional Feature:
- Macro: SAP_CTRL_JMP_EN
- Defined:
  - Adds output o_lp (1 bit, PC load).
  - Adds JMP opcode 0011: T4 ei,lp; T5,T6 none.
  - o_lp obeys the same pause, halt and reset gating as the other outputs.
- Undefined:
  - No o_lp port.
  - 0011 decodes as NOP.

Test Plan:
- Reset with clr=1 mid-T5, then release with i_run=1 -> o_tstate=000001, o_ep=o_lm=1, o_hlt=0, with no clock edge required.
- i_run=1, opcode 0001 (ADD) held -> over 6 clocks the exact sequence T1{ep,lm} T2{cp} T3{ce,li} T4{ei,lm} T5{ce,lb} T6{eu,la}, then back to T1.
- Opcode 0010 (SUB) -> identical to ADD except o_su=1 only in T6. Opcode 1110 (OUT) -> T4 {ea,lo}, with T5 and T6 all zeros.
- Drop i_run=0 during T3 for 3 clocks -> o_tstate stays 000100 and all control outputs are 0. Raise i_run -> o_ce=o_li=1 again, then T4 follows next edge.
- Opcode 1111 (HLT) -> after the T4 edge o_hlt=1, o_tstate=001000 frozen, outputs 0 for 10+ clocks. Pulse clr -> T1, o_hlt=0.
- With SAP_CTRL_JMP_EN, opcode 0011 -> T4 o_ei=o_lp=1. Without it -> T4..T6 all zeros. Every scenario checks the one-hot bus-driver assertion.
